instruction_fetch_unit: RTL
===========================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 Parameter FETCH_CNT_W, default 32, width of fetched-instruction counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports exactly as listed below.
REQ-004 Clk  input  1  rising-edge clock for all state.
REQ-005 Reset  input  1  asynchronous active-low reset.
REQ-006 Address  output  32  fetch byte address driven to instruction memory; equals PC.
REQ-007 Instruction  input  32  combinational read data from instruction memory for Address.
REQ-008 Stall  input  1  hazard-unit hold; freezes PC and IF/ID register.
REQ-009 BranchTaken  input  1  redirect request from MEM stage, single-cycle qualifier.
REQ-010 BranchTarget  input  32  redirect byte address, valid with BranchTaken.
REQ-011 Halt  input  1  halt request from decode; stops sequential fetch.
REQ-012 IF_ID_Instruction  output  32  registered instruction to decode.
REQ-013 IF_ID_PCPlus4  output  32  registered PC+4 of that instruction.
REQ-014 IF_ID_Valid  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-015 Misaligned  output  1  registered sticky flag: a redirect target had nonzero bits [1:0].
REQ-016 FetchCount  output  FETCH_CNT_W  number of valid instructions latched into IF/ID.
REQ-017 FlushCount  output  16  number of accepted redirects.

Function
REQ-018 FSM states SHALL be BOOT, RUN, HALTED; encoding is free.
REQ-019 BOOT SHALL last exactly one cycle after reset release, with PC held and a bubble loaded into IF/ID, then go to RUN.
REQ-020 Per-cycle priority SHALL be: reset > BranchTaken > Stall > Halt > sequential fetch.
REQ-021 RUN with no event: PC <= PC+4 (mod 2^32); IF/ID <= {Instruction, PC+4, Valid=1}; FetchCount increments.
REQ-022 Stall=1 (no BranchTaken): PC, IF/ID and FetchCount hold; FSM state holds.
REQ-023 BranchTaken=1, any state including Stall=1 or HALTED: PC <= {BranchTarget[31:2],2'b00}; IF/ID <= bubble; FlushCount increments; next state RUN.
REQ-024 Bubble SHALL be Instruction=32'h00000000, PCPlus4=32'h00000000, Valid=0.
REQ-025 A redirect with BranchTarget[1:0]!=0 SHALL set Misaligned, which stays 1 until reset.
REQ-026 Halt=1 in RUN (no BranchTaken, no Stall): IF/ID <= bubble; PC holds; next state HALTED.
REQ-027 HALTED: PC holds, IF/ID loads a bubble every cycle, and Halt/Stall are ignored; the state is left only via BranchTaken or reset.
REQ-028 The first instruction fetched after a redirect SHALL appear in IF/ID exactly 1 cycle after the redirect cycle.
REQ-029 FetchCount SHALL saturate at all-ones and FlushCount at 16'hFFFF, with no wrap.
REQ-030 PC SHALL wrap from 32'hFFFFFFFC to 32'h00000000 without any flag.
REQ-031 Address SHALL be purely PC; there is no combinational path from Stall, BranchTaken or Halt to Address.

Reset
REQ-032 Reset low SHALL immediately force: PC=RESET_PC, state=BOOT, IF/ID bubble, Misaligned=0, FetchCount=0, FlushCount=0.
REQ-033 Reset asserted mid-stall, mid-halt or during redirect SHALL override all inputs; deassertion is synchronized externally.

Verification
REQ-034 Reset release, memory holding 0x11,0x22,0x33 at words 0-2 -> cycle 1 bubble; cycles 2-4 IF_ID_Instruction = 0x11/0x22/0x33, PCPlus4 = 4/8/12; FetchCount = 3.
REQ-035 Stall high 3 cycles at PC=8 -> Address stays 8, IF/ID and FetchCount frozen; fetch resumes at 8 after Stall drops.
REQ-036 BranchTaken with target 0x40 while Stall=1 -> next cycle Address=0x40, IF_ID_Valid=0, FlushCount=1; the cycle after, IF/ID holds mem[0x40], PCPlus4=0x44.
REQ-037 Halt at PC=0x10 -> HALTED, Address fixed at 0x10, Valid=0 for 10 cycles; BranchTaken target 0x20 -> resumes at 0x20.
REQ-038 Redirect to 0x43 -> Address=0x40, Misaligned=1 and remains 1 until reset low.
REQ-039 Preload FetchCount near all-ones (FETCH_CNT_W=4, 20 fetches) -> holds at 4'hF; PC at 0xFFFFFFFC with a sequential fetch -> Address=0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, fetches one word per cycle into the IF/ID register, honours redirect/stall/halt.
// Latency 1 cycle Address->IF/ID; Stall freezes PC and IF/ID, BranchTaken always wins.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h00000000,
  parameter int          FETCH_CNT_W = 32
) (
  input  logic                   Clk,
  input  logic                   Reset,
  output logic [31:0]            Address,
  input  logic [31:0]            Instruction,
  input  logic                   Stall,
  input  logic                   BranchTaken,
  input  logic [31:0]            BranchTarget,
  input  logic                   Halt,
  output logic [31:0]            IF_ID_Instruction,
  output logic [31:0]            IF_ID_PCPlus4,
  output logic                   IF_ID_Valid,
  output logic                   Misaligned,
  output logic [FETCH_CNT_W-1:0] FetchCount,
  output logic [15:0]            FlushCount
);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  localparam logic [FETCH_CNT_W-1:0] FETCH_ONE = 1;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        fetch;
  logic        load_bubble;

  assign pc_plus4 = pc + 32'd4;
  assign Address  = pc;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (BranchTaken) begin
      state_nxt = RUN;
    end else begin
      case (state)
        BOOT:    state_nxt = RUN;
        RUN:     if (!Stall && Halt) state_nxt = HALTED;
        HALTED:  state_nxt = HALTED;
        default: state_nxt = BOOT;
      endcase
    end
  end

  // BOOT ignores Stall/Halt so it lasts exactly one cycle; only RUN can be stalled
  always_comb begin
    redirect    = BranchTaken;
    fetch       = 1'b0;
    load_bubble = 1'b0;
    if (BranchTaken) begin
      load_bubble = 1'b1;
    end else begin
      case (state)
        BOOT:   load_bubble = 1'b1;
        RUN: begin
          if (Stall)     load_bubble = 1'b0;
          else if (Halt) load_bubble = 1'b1;
          else           fetch       = 1'b1;
        end
        HALTED:  load_bubble = 1'b1;
        default: load_bubble = 1'b1;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)        pc <= RESET_PC;
    else if (redirect) pc <= {BranchTarget[31:2], 2'b00};
    else if (fetch)    pc <= pc_plus4;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      IF_ID_Instruction <= 32'h0;
      IF_ID_PCPlus4     <= 32'h0;
      IF_ID_Valid       <= 1'b0;
    end else if (fetch) begin
      IF_ID_Instruction <= Instruction;
      IF_ID_PCPlus4     <= pc_plus4;
      IF_ID_Valid       <= 1'b1;
    end else if (load_bubble) begin
      IF_ID_Instruction <= 32'h0;
      IF_ID_PCPlus4     <= 32'h0;
      IF_ID_Valid       <= 1'b0;
    end
  end

  // Counters saturate rather than wrap so software sees a pinned value on overflow
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      FetchCount <= '0;
      FlushCount <= 16'h0;
      Misaligned <= 1'b0;
    end else begin
      if (fetch && (FetchCount != '1))
        FetchCount <= FetchCount + FETCH_ONE;
      if (redirect && (FlushCount != 16'hFFFF))
        FlushCount <= FlushCount + 16'd1;
      if (redirect && (BranchTarget[1:0] != 2'b00))
        Misaligned <= 1'b1;
    end
  end

endmodule
